// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the hazard/forwarding control unit.
// Holds the EX operand-select encoding used by top and bench.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WR  = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/pipe_hazard_ctrl_slot.sv
// One pipeline stage register: valid flag plus a packed payload.
// Ports: clk, rst_n, bubble, d_valid, d -> q_valid, q.
module pipe_hazard_ctrl_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         bubble,
  input  logic         d_valid,
  input  logic [W-1:0] d,
  output logic         q_valid,
  output logic [W-1:0] q
);

  // An invalid input is stored as a bubble so that no stale
  // regwr/load/ctrl bits linger behind a cleared valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_valid <= 1'b0;
      q       <= '0;
    end else if (bubble || !d_valid) begin
      q_valid <= 1'b0;
      q       <= '0;
    end else begin
      q_valid <= 1'b1;
      q       <= d;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and control pipeline for the 5-stage core.
// In: ID decode + ex_br_taken. Out: stall/flush/fwd, stage ctrl, counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_W     = 5,
  parameter int CTRL_W    = 8,
  parameter int FWD_EN    = 1,
  parameter int RF_WFIRST = 1,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_W-1:0]  id_rw,
  input  logic              id_regwr,
  input  logic              id_load,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              ex_br_taken,
  output logic              stall,
  output logic              flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [CTRL_W-1:0] mem_ctrl,
  output logic [CTRL_W-1:0] wr_ctrl,
  output logic              ex_valid,
  output logic              mem_valid,
  output logic              wr_valid,
  output logic [REG_W-1:0]  wr_rw,
  output logic              wr_regwr,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // EX keeps sources for forwarding; MEM/WR only need the dest.
  localparam int EW = 3*REG_W + 4 + CTRL_W;
  localparam int MW = REG_W + 1 + CTRL_W;

  logic [EW-1:0]     id_vec;
  logic [EW-1:0]     ex_vec;
  logic [MW-1:0]     mem_vec;
  logic [MW-1:0]     wr_vec;

  logic [REG_W-1:0]  ex_rs;
  logic [REG_W-1:0]  ex_rt;
  logic              ex_use_rs;
  logic              ex_use_rt;
  logic [REG_W-1:0]  ex_rw;
  logic              ex_regwr;
  logic              ex_load;
  logic [REG_W-1:0]  mem_rw;
  logic              mem_regwr;
  logic              wr_rg;

  logic              hit_ex;
  logic              hit_mem;
  logic              hit_wr;
  logic              stall_raw;

  assign id_vec = {id_rs, id_rt, id_use_rs, id_use_rt,
                   id_rw, id_regwr, id_load, id_ctrl};

  assign {ex_rs, ex_rt, ex_use_rs, ex_use_rt,
          ex_rw, ex_regwr, ex_load, ex_ctrl} = ex_vec;
  assign {mem_rw, mem_regwr, mem_ctrl} = mem_vec;
  assign {wr_rw, wr_rg, wr_ctrl} = wr_vec;

  pipe_hazard_ctrl_slot #(.W(EW)) u_ex (
    .clk     (clk),
    .rst_n   (rst_n),
    .bubble  (stall | flush),
    .d_valid (id_valid),
    .d       (id_vec),
    .q_valid (ex_valid),
    .q       (ex_vec)
  );

  pipe_hazard_ctrl_slot #(.W(MW)) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .bubble  (1'b0),
    .d_valid (ex_valid),
    .d       ({ex_rw, ex_regwr, ex_ctrl}),
    .q_valid (mem_valid),
    .q       (mem_vec)
  );

  pipe_hazard_ctrl_slot #(.W(MW)) u_wr (
    .clk     (clk),
    .rst_n   (rst_n),
    .bubble  (1'b0),
    .d_valid (mem_valid),
    .d       ({mem_rw, mem_regwr, mem_ctrl}),
    .q_valid (wr_valid),
    .q       (wr_vec)
  );

  assign wr_regwr = wr_valid & wr_rg;

  function automatic logic hit(
    input logic             v,
    input logic             rg,
    input logic [REG_W-1:0] rw,
    input logic [REG_W-1:0] src,
    input logic             u
  );
    return v & rg & (rw == src) & (src != '0) & u;
  endfunction

  // Youngest producer (MEM) wins over WR.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_W-1:0] src,
    input logic             u
  );
    if (FWD_EN == 0)
      return FWD_RF;
    else if (hit(mem_valid, mem_regwr, mem_rw, src, u))
      return FWD_MEM;
    else if (hit(wr_valid, wr_rg, wr_rw, src, u))
      return FWD_WR;
    else
      return FWD_RF;
  endfunction

  assign fwd_a = fwd_sel(ex_rs, ex_use_rs);
  assign fwd_b = fwd_sel(ex_rt, ex_use_rt);

  assign hit_ex  = hit(ex_valid, ex_regwr, ex_rw, id_rs, id_use_rs)
                 | hit(ex_valid, ex_regwr, ex_rw, id_rt, id_use_rt);
  assign hit_mem = hit(mem_valid, mem_regwr, mem_rw, id_rs, id_use_rs)
                 | hit(mem_valid, mem_regwr, mem_rw, id_rt, id_use_rt);
  assign hit_wr  = hit(wr_valid, wr_rg, wr_rw, id_rs, id_use_rs)
                 | hit(wr_valid, wr_rg, wr_rw, id_rt, id_use_rt);

  // With forwarding only lw->use needs a bubble; without it every
  // RAW waits until the producer has reached the regfile.
  always_comb begin
    stall_raw = 1'b0;
    if (FWD_EN != 0)
      stall_raw = ex_load & hit_ex;
    else
      stall_raw = hit_ex | hit_mem | ((RF_WFIRST == 0) & hit_wr);
  end

  assign flush = ex_br_taken & ex_valid;
  assign stall = id_valid & stall_raw & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush && flush_cnt != '1)
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench: three configurations driven with shared ID stimulus,
// each checked against an instruction-level reference model.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_rs, id_rt, id_rw;
  logic       id_use_rs, id_use_rt, id_regwr, id_load;
  logic [7:0] id_ctrl;
  logic       ex_br_taken;

  logic       st_o [3];
  logic       fl_o [3];
  logic [1:0] fa_o [3];
  logic [1:0] fb_o [3];
  logic [7:0] ec_o [3];
  logic [7:0] mc_o [3];
  logic [7:0] wc_o [3];
  logic       ev_o [3];
  logic       mv_o [3];
  logic       wv_o [3];
  logic [4:0] wrw_o [3];
  logic       wrg_o [3];
  logic [15:0] sc0, fc0;
  logic [3:0]  sc1, fc1, sc2, fc2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl u0 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .id_rw(id_rw), .id_regwr(id_regwr),
    .id_load(id_load), .id_ctrl(id_ctrl), .ex_br_taken(ex_br_taken),
    .stall(st_o[0]), .flush(fl_o[0]), .fwd_a(fa_o[0]), .fwd_b(fb_o[0]),
    .ex_ctrl(ec_o[0]), .mem_ctrl(mc_o[0]), .wr_ctrl(wc_o[0]),
    .ex_valid(ev_o[0]), .mem_valid(mv_o[0]), .wr_valid(wv_o[0]),
    .wr_rw(wrw_o[0]), .wr_regwr(wrg_o[0]),
    .stall_cnt(sc0), .flush_cnt(fc0)
  );

  pipe_hazard_ctrl #(.FWD_EN(0), .RF_WFIRST(1), .CNT_W(4)) u1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .id_rw(id_rw), .id_regwr(id_regwr),
    .id_load(id_load), .id_ctrl(id_ctrl), .ex_br_taken(ex_br_taken),
    .stall(st_o[1]), .flush(fl_o[1]), .fwd_a(fa_o[1]), .fwd_b(fb_o[1]),
    .ex_ctrl(ec_o[1]), .mem_ctrl(mc_o[1]), .wr_ctrl(wc_o[1]),
    .ex_valid(ev_o[1]), .mem_valid(mv_o[1]), .wr_valid(wv_o[1]),
    .wr_rw(wrw_o[1]), .wr_regwr(wrg_o[1]),
    .stall_cnt(sc1), .flush_cnt(fc1)
  );

  pipe_hazard_ctrl #(.FWD_EN(0), .RF_WFIRST(0), .CNT_W(4)) u2 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .id_rw(id_rw), .id_regwr(id_regwr),
    .id_load(id_load), .id_ctrl(id_ctrl), .ex_br_taken(ex_br_taken),
    .stall(st_o[2]), .flush(fl_o[2]), .fwd_a(fa_o[2]), .fwd_b(fb_o[2]),
    .ex_ctrl(ec_o[2]), .mem_ctrl(mc_o[2]), .wr_ctrl(wc_o[2]),
    .ex_valid(ev_o[2]), .mem_valid(mv_o[2]), .wr_valid(wv_o[2]),
    .wr_rw(wrw_o[2]), .wr_regwr(wrg_o[2]),
    .stall_cnt(sc2), .flush_cnt(fc2)
  );

  // ---------------- reference model ----------------
  typedef struct {
    bit       v;
    bit [4:0] rs, rt;
    bit       urs, urt;
    bit [4:0] rw;
    bit       rg, ld;
    bit [7:0] ctrl;
  } ins_t;

  localparam ins_t NOP = '{v:0, rs:0, rt:0, urs:0, urt:0,
                           rw:0, rg:0, ld:0, ctrl:0};

  int          fe   [3] = '{1, 0, 0};
  int          wf   [3] = '{1, 1, 0};
  int unsigned cmax [3] = '{65535, 15, 15};

  ins_t        m_ex [3];
  ins_t        m_mem[3];
  ins_t        m_wr [3];
  int unsigned m_sc [3];
  int unsigned m_fc [3];

  function automatic ins_t cur_id();
    ins_t t;
    t.v = id_valid; t.rs = id_rs; t.rt = id_rt;
    t.urs = id_use_rs; t.urt = id_use_rt;
    t.rw = id_rw; t.rg = id_regwr; t.ld = id_load;
    t.ctrl = id_ctrl;
    return t;
  endfunction

  // Does producer p write the register consumer reads as src?
  function automatic bit writes(ins_t p, bit [4:0] src, bit u);
    return p.v && p.rg && u && src != 0 && p.rw == src;
  endfunction

  function automatic bit reads_from(ins_t p, ins_t c);
    return writes(p, c.rs, c.urs) || writes(p, c.rt, c.urt);
  endfunction

  function automatic int m_fwd(int i, bit [4:0] src, bit u);
    if (fe[i] == 0) return 0;
    if (writes(m_mem[i], src, u)) return 1;
    if (writes(m_wr[i], src, u)) return 2;
    return 0;
  endfunction

  function automatic bit m_flush(int i);
    return ex_br_taken && m_ex[i].v;
  endfunction

  function automatic bit m_stall(int i);
    ins_t c;
    bit   raw;
    c = cur_id();
    if (!c.v || m_flush(i)) return 0;
    if (fe[i] != 0)
      raw = m_ex[i].ld && reads_from(m_ex[i], c);
    else
      raw = reads_from(m_ex[i], c) || reads_from(m_mem[i], c)
         || (wf[i] == 0 && reads_from(m_wr[i], c));
    return raw;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_ex[i] = NOP; m_mem[i] = NOP; m_wr[i] = NOP;
      m_sc[i] = 0; m_fc[i] = 0;
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] d_sc(int i);
    case (i)
      0: return 32'(sc0);
      1: return 32'(sc1);
      default: return 32'(sc2);
    endcase
  endfunction

  function automatic logic [31:0] d_fc(int i);
    case (i)
      0: return 32'(fc0);
      1: return 32'(fc1);
      default: return 32'(fc2);
    endcase
  endfunction

  task automatic eval();
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("u%0d.stall", i), 32'(st_o[i]), 32'(m_stall(i)));
      chk($sformatf("u%0d.flush", i), 32'(fl_o[i]), 32'(m_flush(i)));
      chk($sformatf("u%0d.fwd_a", i), 32'(fa_o[i]),
          32'(m_fwd(i, m_ex[i].rs, m_ex[i].urs)));
      chk($sformatf("u%0d.fwd_b", i), 32'(fb_o[i]),
          32'(m_fwd(i, m_ex[i].rt, m_ex[i].urt)));
      chk($sformatf("u%0d.ex_valid", i), 32'(ev_o[i]), 32'(m_ex[i].v));
      chk($sformatf("u%0d.mem_valid", i), 32'(mv_o[i]), 32'(m_mem[i].v));
      chk($sformatf("u%0d.wr_valid", i), 32'(wv_o[i]), 32'(m_wr[i].v));
      chk($sformatf("u%0d.ex_ctrl", i), 32'(ec_o[i]), 32'(m_ex[i].ctrl));
      chk($sformatf("u%0d.mem_ctrl", i), 32'(mc_o[i]), 32'(m_mem[i].ctrl));
      chk($sformatf("u%0d.wr_ctrl", i), 32'(wc_o[i]), 32'(m_wr[i].ctrl));
      chk($sformatf("u%0d.wr_rw", i), 32'(wrw_o[i]),
          32'(m_wr[i].v ? m_wr[i].rw : 5'd0));
      chk($sformatf("u%0d.wr_regwr", i), 32'(wrg_o[i]),
          32'(m_wr[i].v && m_wr[i].rg));
      chk($sformatf("u%0d.stall_cnt", i), d_sc(i), 32'(m_sc[i]));
      chk($sformatf("u%0d.flush_cnt", i), d_fc(i), 32'(m_fc[i]));
    end
  endtask

  // Advance one clock; model moves with the DUT unless in reset.
  task automatic step();
    ins_t nx [3];
    bit   s, f;
    for (int i = 0; i < 3; i++) begin
      s = m_stall(i);
      f = m_flush(i);
      nx[i] = (s || f || !id_valid) ? NOP : cur_id();
      if (rst_n) begin
        if (s && m_sc[i] < cmax[i]) m_sc[i]++;
        if (f && m_fc[i] < cmax[i]) m_fc[i]++;
      end
    end
    @(posedge clk);
    if (rst_n) begin
      for (int i = 0; i < 3; i++) begin
        m_wr[i]  = m_mem[i];
        m_mem[i] = m_ex[i];
        m_ex[i]  = nx[i];
      end
    end
    @(negedge clk);
  endtask

  task automatic set_id(input bit v, input int rs, input int rt,
                        input bit urs, input bit urt, input int rw,
                        input bit rg, input bit ld);
    id_valid  = v;
    id_rs     = 5'(rs);
    id_rt     = 5'(rt);
    id_use_rs = urs;
    id_use_rt = urt;
    id_rw     = 5'(rw);
    id_regwr  = rg;
    id_load   = ld;
    id_ctrl   = v ? 8'($urandom_range(1, 255)) : 8'h00;
  endtask

  task automatic nop(); set_id(0, 0, 0, 0, 0, 0, 0, 0); endtask

  task automatic rand_id();
    set_id($urandom_range(0, 9) < 8,
           $urandom_range(0, 3), $urandom_range(0, 3),
           $urandom_range(0, 9) < 8, $urandom_range(0, 1),
           $urandom_range(0, 3), $urandom_range(0, 9) < 8,
           $urandom_range(0, 9) < 3);
    ex_br_taken = $urandom_range(0, 9) == 0;
  endtask

  task automatic drain();
    nop();
    ex_br_taken = 1'b0;
    repeat (3) begin eval(); step(); end
  endtask

  initial begin
    rst_n = 1'b0;
    ex_br_taken = 1'b0;
    nop();
    model_reset();
    @(negedge clk);
    eval();
    @(negedge clk);
    rst_n = 1'b1;

    // add $3,$1,$2 ; sub $4,$3,$5 -> sub sees EX/MEM forward
    set_id(1, 1, 2, 1, 1, 3, 1, 0); eval(); step();
    set_id(1, 3, 5, 1, 1, 4, 1, 0); eval(); step();
    nop(); eval();
    chk("add_sub.fwd_a", 32'(fa_o[0]), 32'd1);
    chk("add_sub.stall", 32'(st_o[0]), 32'd0);
    step();
    drain();

    // add $3 ; nop ; or $6,$3,$3 -> WR forward on both
    set_id(1, 1, 2, 1, 1, 3, 1, 0); eval(); step();
    nop(); eval(); step();
    set_id(1, 3, 3, 1, 1, 6, 1, 0); eval(); step();
    nop(); eval();
    chk("gap1.fwd_a", 32'(fa_o[0]), 32'd2);
    chk("gap1.fwd_b", 32'(fb_o[0]), 32'd2);
    step();
    drain();

    // add $3 ; add $3 ; or -> MEM copy wins over WR
    set_id(1, 1, 2, 1, 1, 3, 1, 0); eval(); step();
    set_id(1, 1, 2, 1, 1, 3, 1, 0); eval(); step();
    set_id(1, 3, 3, 1, 1, 6, 1, 0); eval(); step();
    nop(); eval();
    chk("both.fwd_a", 32'(fa_o[0]), 32'd1);
    chk("both.fwd_b", 32'(fb_o[0]), 32'd1);
    step();
    drain();

    // lw $2,0($1) ; add $4,$2,$2 -> one stall then WR forward
    set_id(1, 1, 0, 1, 0, 2, 1, 1); eval(); step();
    set_id(1, 2, 2, 1, 1, 4, 1, 0); eval();
    chk("lw.stall1", 32'(st_o[0]), 32'd1);
    step();
    eval();
    chk("lw.stall2", 32'(st_o[0]), 32'd0);
    chk("lw.bubble", 32'(ev_o[0]), 32'd0);
    step();
    nop(); eval();
    chk("lw.fwd_a", 32'(fa_o[0]), 32'd2);
    chk("lw.fwd_b", 32'(fb_o[0]), 32'd2);
    step();
    drain();

    // taken branch while lw-use pending: flush overrides stall
    set_id(1, 1, 0, 1, 0, 2, 1, 1); eval(); step();
    set_id(1, 2, 2, 1, 1, 4, 1, 0);
    ex_br_taken = 1'b1;
    eval();
    chk("br.flush", 32'(fl_o[0]), 32'd1);
    chk("br.stall", 32'(st_o[0]), 32'd0);
    step();
    ex_br_taken = 1'b0;
    nop(); eval();
    chk("br.bubble", 32'(ev_o[0]), 32'd0);
    chk("br.flush_cnt", 32'(fc0), 32'd1);
    step();
    drain();

    // no forwarding: RAW stalls 2 (write-first) / 3 cycles
    set_id(1, 1, 2, 1, 1, 3, 1, 0); eval(); step();
    set_id(1, 3, 5, 1, 1, 4, 1, 0); eval();
    chk("nf.c1.u1", 32'(st_o[1]), 32'd1);
    chk("nf.c1.u2", 32'(st_o[2]), 32'd1);
    step(); eval();
    chk("nf.c2.u1", 32'(st_o[1]), 32'd1);
    chk("nf.c2.u2", 32'(st_o[2]), 32'd1);
    step(); eval();
    chk("nf.c3.u1", 32'(st_o[1]), 32'd0);
    chk("nf.c3.u2", 32'(st_o[2]), 32'd1);
    step(); eval();
    chk("nf.c4.u2", 32'(st_o[2]), 32'd0);
    step();
    nop(); eval();
    chk("nf.fwd_a", 32'(fa_o[1]), 32'd0);
    step();
    drain();

    // writes to $0 never create a hazard
    set_id(1, 1, 2, 1, 1, 0, 1, 1); eval(); step();
    set_id(1, 0, 0, 1, 1, 4, 1, 0); eval();
    chk("r0.u0", 32'(st_o[0]), 32'd0);
    chk("r0.u1", 32'(st_o[1]), 32'd0);
    chk("r0.u2", 32'(st_o[2]), 32'd0);
    step();
    drain();

    // random traffic
    repeat (200) begin rand_id(); eval(); step(); end

    // reset mid-stream: everything dropped at once
    rand_id();
    rst_n = 1'b0;
    model_reset();
    eval();
    chk("rst.wr_regwr", 32'(wrg_o[0]), 32'd0);
    chk("rst.ex_valid", 32'(ev_o[0]), 32'd0);
    step();
    rst_n = 1'b1;

    repeat (200) begin rand_id(); eval(); step(); end
    chk("sat.u1", 32'(sc1), 32'd15);
    chk("sat.u2", 32'(sc2), 32'd15);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
